// File: rtl/udp_tx_arbiter.sv
// Two-port per-frame UDP transmit arbiter feeding the MAC tx_udp_* interface.
// Port 0 carries controller replies, port 1 the acquisition stream; a stall watchdog aborts hung frames.
module udp_tx_arbiter #(
    parameter int unsigned ROUND_ROBIN = 0,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  s_hdr_valid,
    output logic [1:0]  s_hdr_ready,
    input  logic [63:0] s_ip_dest_ip,
    input  logic [31:0] s_udp_source_port,
    input  logic [31:0] s_udp_dest_port,
    input  logic [31:0] s_udp_length,
    input  logic [15:0] s_payload_tdata,
    input  logic [1:0]  s_payload_tvalid,
    output logic [1:0]  s_payload_tready,
    input  logic [1:0]  s_payload_tlast,
    input  logic [1:0]  s_payload_tuser,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [31:0] m_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [7:0]  m_payload_tdata,
    output logic        m_payload_tvalid,
    input  logic        m_payload_tready,
    output logic        m_payload_tlast,
    output logic        m_payload_tuser,
    output logic [1:0]  grant,
    output logic [15:0] abort_count
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StHdr, StPayload, StAbort, StDrain} state_t;

    state_t        state;
    logic          sel;
    logic          rr_ptr;
    logic [CW-1:0] idle_cnt;

    logic any_req;
    logic win;
    logic src_valid;
    logic src_last;

    always_comb begin
        any_req   = |s_hdr_valid;
        src_valid = s_payload_tvalid[sel];
        src_last  = s_payload_tlast[sel];
        // rr_ptr names the port that wins the next contested grant
        if (ROUND_ROBIN != 0 && s_hdr_valid == 2'b11) begin
            win = rr_ptr;
        end else begin
            win = ~s_hdr_valid[0];
        end
    end

    always_comb begin
        s_hdr_ready      = '0;
        s_payload_tready = '0;
        m_payload_tdata  = '0;
        m_payload_tvalid = 1'b0;
        m_payload_tlast  = 1'b0;
        m_payload_tuser  = 1'b0;
        if (!rst) begin
            unique case (state)
                StIdle: begin
                    if (any_req) s_hdr_ready[win] = 1'b1;
                end
                StPayload: begin
                    m_payload_tdata       = sel ? s_payload_tdata[15:8] : s_payload_tdata[7:0];
                    m_payload_tvalid      = src_valid;
                    m_payload_tlast       = src_last;
                    m_payload_tuser       = s_payload_tuser[sel];
                    s_payload_tready[sel] = m_payload_tready;
                end
                StAbort: begin
                    m_payload_tvalid = 1'b1;
                    m_payload_tlast  = 1'b1;
                    m_payload_tuser  = 1'b1;
                end
                StDrain: begin
                    s_payload_tready[sel] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            sel               <= 1'b0;
            rr_ptr            <= 1'b0;
            idle_cnt          <= '0;
            grant             <= '0;
            m_hdr_valid       <= 1'b0;
            m_ip_dest_ip      <= '0;
            m_udp_source_port <= '0;
            m_udp_dest_port   <= '0;
            m_udp_length      <= '0;
            abort_count       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        sel               <= win;
                        rr_ptr            <= ~win;
                        grant             <= win ? 2'b10 : 2'b01;
                        m_ip_dest_ip      <= win ? s_ip_dest_ip[63:32] : s_ip_dest_ip[31:0];
                        m_udp_source_port <= win ? s_udp_source_port[31:16]
                                                 : s_udp_source_port[15:0];
                        m_udp_dest_port   <= win ? s_udp_dest_port[31:16] : s_udp_dest_port[15:0];
                        m_udp_length      <= win ? s_udp_length[31:16] : s_udp_length[15:0];
                        m_hdr_valid       <= 1'b1;
                        state             <= StHdr;
                    end
                end
                StHdr: begin
                    if (m_hdr_ready) begin
                        m_hdr_valid <= 1'b0;
                        idle_cnt    <= '0;
                        state       <= StPayload;
                    end
                end
                StPayload: begin
                    if (src_valid) begin
                        // MAC backpressure is not a source stall
                        idle_cnt <= '0;
                        if (m_payload_tready && src_last) begin
                            grant <= '0;
                            state <= StIdle;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        idle_cnt <= CW'(TIMEOUT);
                        state    <= StAbort;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                StAbort: begin
                    if (m_payload_tready) begin
                        if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (src_valid && src_last) begin
                        grant <= '0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
